dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for CPU data accesses, using a valid/ready request/response handshake.
- Holds a DEPTH-word storage array and serves one word-sized read or write per transaction, with a fixed, configurable latency.
- Sits between the CPU load/store path (the requester) and its storage.
- Used where data memory is not single-cycle, e.g. multi-cycle and pipelined CPU variants.

Parameters:
- DEPTH, 64: number of 32-bit words; power of two, at least 2.
- LATENCY, 2: cycles from request acceptance to resp_valid; at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  requester presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  32  load data; 0 for stores.
- resp_err  out  1  access error flag (see Optional Feature).

Behaviour:
- States: IDLE, WAIT, RESP. Internal registers: addr_q, write_q, wdata_q, and a down-counter cnt of width clog2(LATENCY)+1.
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - All storage words cleared to 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- IDLE:
  - req_ready=1, resp_valid=0.
  - On a rising edge with req_valid=1: latch addr/write/wdata, load cnt=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0, resp_valid=0.
  - If cnt!=0: decrement cnt.
  - If cnt==0: perform the access and go to RESP.
    - Store: mem[idx] <= wdata_q, resp_rdata <= 0.
    - Load: resp_rdata <= mem[idx].
- Latency: a request accepted at edge N gives resp_valid=1 immediately after edge N+LATENCY. With LATENCY=1, the response appears after the very next edge.
- RESP:
  - req_ready=0, resp_valid=1.
  - resp_rdata and resp_err stay stable until the response is consumed.
  - On an edge with resp_ready=1: go to IDLE and clear resp_valid. resp_rdata and resp_err hold their last values.
- No overlap between transactions:
  - A new request is never accepted in the same cycle a response is consumed.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- Index: idx = addr_q[clog2(DEPTH)+1:2]. Higher address bits are ignored, so addresses alias modulo DEPTH*4 bytes.
- A store is committed only at the WAIT->RESP edge. A load therefore sees any store completed earlier; there is no forwarding from a pending store.
- req_* inputs are ignored while req_ready=0. A change on req_* during WAIT/RESP has no effect.
- Reset asserted mid-transaction:
  - The transaction is abandoned and the storage is cleared.
  - A pending store is not committed.
  - No response is produced.
- Concurrent req_valid and rst deassertion on the same edge: the request is not accepted; acceptance requires rst=1 at the edge.

Optional Feature:
- Macro: DMEM_RESPONDER_ERR_EN.
- Defined:
  - At the WAIT->RESP edge, an error is raised if addr_q[1:0]!=0 (misaligned) or addr_q >= DEPTH*4 (out of range).
  - On error: no storage access (a store is dropped), resp_rdata=0, resp_err=1.
  - Otherwise resp_err=0.
- Not defined:
  - resp_err is tied to 0.
  - addr_q[1:0] is ignored (word-aligned access), and out-of-range addresses alias per the index rule.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; a load from 0x0 after release returns 0x00000000.
- Write-then-read, LATENCY=2:
  - Store 0xDEADBEEF to 0x10, accepted at edge N -> resp_valid rises after edge N+2 with rdata=0.
  - Load from 0x10 -> rdata=0xDEADBEEF, also 2 cycles after acceptance.
- Backpressure: load with resp_ready=0 for 3 cycles in RESP -> resp_valid and resp_rdata held constant, req_ready=0 throughout; resp_ready=1 -> IDLE next edge, req_ready=1.
- Reset mid-op: store 0x12345678 to 0x20, rst=0 during WAIT -> resp_valid never asserts; a later load from 0x20 returns 0.
- Aliasing, DEPTH=64, macro off: store 0xA5A5A5A5 to 0x100; load from 0x000 returns 0xA5A5A5A5; load from 0x003 returns 0xA5A5A5A5.
- DMEM_RESPONDER_ERR_EN, DEPTH=64:
  - Store to 0x102 -> resp_err=1 and the store is dropped.
  - Load from 0x100 -> resp_err=1, rdata=0.
  - Load from 0x0FC -> resp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-wide data memory responder with valid/ready request and response channels and fixed access latency.
// Optional access-error checking (misaligned / out-of-range) is enabled by defining DMEM_RESPONDER_ERR_EN.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [31:0]         addr_q;
   logic                write_q;
   logic [31:0]         wdata_q;
   logic [CNT_W-1:0]    cnt;
   logic [31:0]         rdata_q;
   logic                err_q;
   logic [31:0]         mem [DEPTH];
   logic [IDX_W-1:0]    idx;
   logic                access_fire;
   logic                acc_err;
   logic                mem_we;
   logic                unused_addr_bits;

   assign idx         = addr_q[IDX_W+1:2];
   assign access_fire = (state_reg == WAIT) && (cnt == '0);
   assign mem_we      = access_fire && write_q && !acc_err;

`ifdef DMEM_RESPONDER_ERR_EN
   assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(DEPTH * 4));
`else
   assign acc_err = 1'b0;
`endif

   // Upper address bits alias and byte offset is ignored when error checking is off.
   assign unused_addr_bits = ^{addr_q[31:IDX_W+2], addr_q[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid) state_next = WAIT;
         WAIT:    if (cnt == '0) state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_reg)
         IDLE:    req_ready  = 1'b1;
         RESP:    resp_valid = 1'b1;
         default: begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state_reg == IDLE && req_valid) begin
         addr_q  <= req_addr;
         write_q <= req_write;
         wdata_q <= req_wdata;
         cnt     <= CNT_W'(LATENCY - 1);
      end else if (state_reg == WAIT) begin
         if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end else begin
            // Stores and faulted accesses return zero data.
            rdata_q <= (write_q || acc_err) ? 32'h0 : mem[idx];
            err_q   <= acc_err;
         end
      end
   end

   // Storage is register-based so that reset can clear every word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_we) begin
         mem[idx] <= wdata_q;
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=64, LATENCY=2).
// Error-flag scenarios are exercised when DMEM_RESPONDER_ERR_EN is defined.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   dmem_responder #(
      .DEPTH   (64),
      .LATENCY (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Called one time unit after a rising edge with the DUT idle.
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hold,
                      input string tag);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      // Garbage on req_* while busy must be ignored.
      req_write = ~wr;
      req_addr  = addr ^ 32'h4;
      req_wdata = ~wdata;
      check({tag, ".wait_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".valid_n0"}, 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      check({tag, ".valid_n1"}, 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      check({tag, ".valid_n2"}, 32'(resp_valid), 32'd1);
      check({tag, ".rdata"}, resp_rdata, exp_rdata);
      check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
         check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
         check({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
      check({tag, ".done_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, ".done_rdata_held"}, resp_rdata, exp_rdata);
      $display("txn %-12s %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d",
               tag, wr ? "ST" : "LD", addr, wdata, resp_rdata, resp_err);
   endtask

   initial begin
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.rdata", resp_rdata, 32'h0);
      check("rst.err", 32'(resp_err), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      txn(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 0, "ld0_reset");
      txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, "st_10");
      txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, "ld_10_bp");

      // Reset during WAIT abandons the pending store and clears storage.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0020;
      req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("midrst.req_ready", 32'(req_ready), 32'd1);
      check("midrst.resp_valid", 32'(resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("midrst.no_resp", 32'(resp_valid), 32'd0);
      end
      $display("txn %-12s ST addr=0x00000020 abandoned by reset", "midrst");
      txn(1'b0, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0, 0, "ld_20");
      txn(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0, 0, "ld_10_clr");

`ifdef DMEM_RESPONDER_ERR_EN
      txn(1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0, 0, "st_00");
      txn(1'b1, 32'h0000_0102, 32'h2222_2222, 32'h0, 1'b1, 0, "st_102_err");
      txn(1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0, 0, "ld_00");
      txn(1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 0, "ld_100_err");
      txn(1'b1, 32'h0000_00FC, 32'h3333_3333, 32'h0, 1'b0, 0, "st_0fc");
      txn(1'b0, 32'h0000_00FC, 32'h0, 32'h3333_3333, 1'b0, 0, "ld_0fc");
`else
      txn(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, "st_100");
      txn(1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_A5A5, 1'b0, 0, "ld_000");
      txn(1'b0, 32'h0000_0003, 32'h0, 32'hA5A5_A5A5, 1'b0, 0, "ld_003");
      txn(1'b1, 32'h0000_00FC, 32'h0F0F_0F0F, 32'h0, 1'b0, 0, "st_0fc");
      txn(1'b0, 32'h0000_01FC, 32'h0, 32'h0F0F_0F0F, 1'b0, 1, "ld_1fc");
      txn(1'b0, 32'h0000_0004, 32'h0, 32'h0000_0000, 1'b0, 0, "ld_004");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
